// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-ported, fixed-latency memory
// between the CPU instruction-fetch port and its data-access port.
//
// Each accepted access runs IDLE -> ACCESS (LATENCY cycles) -> DONE (one ack cycle) -> IDLE.
// Address, write enable and write data are latched at grant, so the memory sees stable
// values even if a requester misbehaves and drops its request early.
//
// Ports:
//   clk_i, rst_i               clock; synchronous active-high reset
//   i_req_i, i_addr_i          instruction fetch request (read only) and address
//   i_rdata_o, i_ack_o         fetch data (held until next fetch capture), one-cycle ack
//   d_req_i, d_we_i            data request, 1 = write
//   d_addr_i, d_wdata_i        data address and store data
//   d_rdata_o, d_ack_o         load data (held until next load capture), one-cycle ack
//   mem_en_o, mem_we_o         memory enable / write enable (high only during ACCESS)
//   mem_addr_o, mem_wdata_o    memory address / write data (zero outside ACCESS)
//   mem_rdata_i                memory read data, valid in the last ACCESS cycle
//   busy_o                     high whenever an access is in flight (not IDLE)
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  // Counter needs to hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  localparam logic GntInstr = 1'b0;
  localparam logic GntData  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Data wins when it is the only requester, or on a tie when instr was granted last.
  logic win_data;
  assign win_data = d_req_i & (~i_req_i | (last_gnt_q == GntInstr));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_req_i || d_req_i) begin
          gnt_d      = win_data;
          last_gnt_d = win_data;
          addr_d     = win_data ? d_addr_i : i_addr_i;
          we_d       = win_data & d_we_i;
          wdata_d    = win_data ? d_wdata_i : '0;
          cnt_d      = CntInit;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Writes leave the port's read-data register untouched.
          if (!we_q) begin
            if (gnt_q == GntData) begin
              d_rdata_d = mem_rdata_i;
            end else begin
              i_rdata_d = mem_rdata_i;
            end
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= GntInstr;
      last_gnt_q <= GntData;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  logic in_access;
  logic in_done;
  assign in_access = (state_q == StAccess);
  assign in_done   = (state_q == StDone);

  always_comb begin
    mem_en_o    = in_access;
    mem_we_o    = in_access & we_q;
    mem_addr_o  = in_access ? addr_q : '0;
    mem_wdata_o = in_access ? wdata_q : '0;
    i_ack_o     = in_done & (gnt_q == GntInstr);
    d_ack_o     = in_done & (gnt_q == GntData);
    i_rdata_o   = i_rdata_q;
    d_rdata_o   = d_rdata_q;
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic, checked each cycle
// against a transaction-level model (grant cycle + fixed latency arithmetic, word memory).
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata;
  logic          i_ack, d_ack, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  // Environment memory: 64 words indexed by the low address bits.
  logic [DW-1:0] ram [64];
  assign mem_rdata = ram[mem_addr[5:0]];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // Second instance built with LATENCY=1.
  logic          l1_i_req;
  logic [AW-1:0] l1_i_addr;
  logic [DW-1:0] l1_i_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
  logic          l1_i_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_busy;
  logic [AW-1:0] l1_mem_addr;
  logic          l1_zero1 = 1'b0;
  logic [AW-1:0] l1_zero_a = '0;
  logic [DW-1:0] l1_zero_d = '0;
  assign l1_mem_rdata = (l1_mem_addr == 32'h4) ? 32'hCAFEF00D : 32'h0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(l1_i_req), .i_addr_i(l1_i_addr), .i_rdata_o(l1_i_rdata), .i_ack_o(l1_i_ack),
    .d_req_i(l1_zero1), .d_we_i(l1_zero1), .d_addr_i(l1_zero_a), .d_wdata_i(l1_zero_d),
    .d_rdata_o(l1_d_rdata), .d_ack_o(l1_d_ack),
    .mem_en_o(l1_mem_en), .mem_we_o(l1_mem_we), .mem_addr_o(l1_mem_addr),
    .mem_wdata_o(l1_mem_wdata), .mem_rdata_i(l1_mem_rdata), .busy_o(l1_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight, described by its grant cycle.
  logic [DW-1:0] refmem [64];
  bit            m_active, m_port, m_we, m_last, m_rst_seen;
  int            m_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata_exp, m_irdata, m_drdata;
  bit            ack_seen [2];

  // Requester state.
  bit            pend [2];
  logic [AW-1:0] r_addr [2];
  logic          r_we;
  logic [DW-1:0] r_wdata;

  // Observations of the DUT.
  int n_ack [2];
  int obs_ack_cyc [2];
  int obs_order [$];
  int obs_ack_q [$];
  int n_we_cyc, n_en_cyc;

  task automatic check_cycle();
    bit e_acc, e_ack, e_busy, port;
    logic [5:0] idx;
    e_acc  = m_active && (cyc >= m_g + 1) && (cyc <= m_g + int'(LAT));
    e_ack  = m_active && (cyc == m_g + int'(LAT) + 1);
    e_busy = m_active && (cyc >= m_g + 1);
    if (e_ack && !m_we) begin
      if (m_port) m_drdata = m_rdata_exp;
      else        m_irdata = m_rdata_exp;
    end
    check_eq("mem_en", 64'(mem_en), 64'(e_acc));
    check_eq("busy", 64'(busy), 64'(e_busy));
    check_eq("i_ack", 64'(i_ack), 64'(e_ack && !m_port));
    check_eq("d_ack", 64'(d_ack), 64'(e_ack && m_port));
    check_eq("i_rdata", 64'(i_rdata), 64'(m_irdata));
    check_eq("d_rdata", 64'(d_rdata), 64'(m_drdata));
    if (e_acc) begin
      check_eq("mem_we", 64'(mem_we), 64'(m_we));
      check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
      if (m_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (m_rst_seen) begin
      check_eq("rst_mem_we", 64'(mem_we), 64'(0));
      check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
      check_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      m_rst_seen = 0;
    end
    if (i_ack) begin n_ack[0]++; obs_ack_cyc[0] = cyc; obs_order.push_back(0); obs_ack_q.push_back(cyc); end
    if (d_ack) begin n_ack[1]++; obs_ack_cyc[1] = cyc; obs_order.push_back(1); obs_ack_q.push_back(cyc); end
    if (mem_we) n_we_cyc++;
    if (mem_en) n_en_cyc++;

    if (rst) begin
      m_active = 0; m_last = 1; m_irdata = '0; m_drdata = '0; m_rst_seen = 1;
      ack_seen[0] = 0; ack_seen[1] = 0;
    end else if (e_ack) begin
      m_active = 0;
      ack_seen[m_port] = 1;
    end else if (!m_active && (i_req || d_req)) begin
      port    = d_req && (!i_req || !m_last);
      m_last  = port;
      m_port  = port;
      m_g     = cyc;
      m_addr  = port ? d_addr : i_addr;
      m_we    = port && d_we;
      m_wdata = d_wdata;
      idx     = m_addr[5:0];
      if (m_we) refmem[idx] = m_wdata;
      else      m_rdata_exp = refmem[idx];
      m_active = 1;
    end
  endtask

  task automatic tick();
    bit wr;
    logic [5:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    check_cycle();
    wr = mem_en && mem_we;
    wa = mem_addr[5:0];
    wd = mem_wdata;
    @(posedge clk);
    if (wr) ram[wa] = wd;
    #1;
    cyc++;
  endtask

  task automatic drive();
    i_req = pend[0]; i_addr = r_addr[0];
    d_req = pend[1]; d_addr = r_addr[1]; d_we = r_we; d_wdata = r_wdata;
  endtask

  // One cycle of requester behaviour: retire acked requests, maybe issue new ones.
  task automatic step_req(input int pct_i, input int pct_d);
    for (int p = 0; p < 2; p++) begin
      if (ack_seen[p]) begin pend[p] = 0; ack_seen[p] = 0; end
    end
    if (!pend[0] && int'($urandom_range(99)) < pct_i) begin
      pend[0] = 1; r_addr[0] = $urandom;
    end
    if (!pend[1] && int'($urandom_range(99)) < pct_d) begin
      pend[1] = 1; r_addr[1] = $urandom; r_we = 1'($urandom_range(1)); r_wdata = $urandom;
    end
    drive();
    tick();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && (m_active || pend[0] || pend[1]); k++) step_req(0, 0);
    check_eq("drain", 64'(m_active || pend[0] || pend[1]), 64'(0));
  endtask

  initial begin
    int t0, nd, ack_at, en_cnt;
    logic [DW-1:0] rd;
    for (int i = 0; i < 64; i++) begin
      rd = $urandom; ram[i] = rd; refmem[i] = rd;
    end
    pend[0] = 0; pend[1] = 0; r_addr[0] = '0; r_addr[1] = '0; r_we = 0; r_wdata = '0;
    drive();
    l1_i_req = 0; l1_i_addr = '0;
    n_ack[0] = 0; n_ack[1] = 0; obs_ack_cyc[0] = 0; obs_ack_cyc[1] = 0;
    n_we_cyc = 0; n_en_cyc = 0;
    m_active = 0; m_last = 1; m_irdata = '0; m_drdata = '0; ack_seen[0] = 0; ack_seen[1] = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_rst_seen = 1;
    rst = 0;

    // Single fetch of 0x10.
    ram[16] = 32'hDEADBEEF; refmem[16] = 32'hDEADBEEF;
    t0 = cyc; pend[0] = 1; r_addr[0] = 32'h10;
    wait_idle();
    check_eq("t1_ack_lat", 64'(obs_ack_cyc[0] - t0), 64'(LAT + 1));
    check_eq("t1_i_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));

    // Write 0x20 then read it back.
    n_we_cyc = 0;
    pend[1] = 1; r_addr[1] = 32'h20; r_we = 1; r_wdata = 32'h12345678;
    wait_idle();
    check_eq("t2_we_cycles", 64'(n_we_cyc), 64'(LAT));
    check_eq("t2_drdata_kept", 64'(d_rdata), 64'(0));
    pend[1] = 1; r_addr[1] = 32'h20; r_we = 0;
    wait_idle();
    check_eq("t2_readback", 64'(d_rdata), 64'(32'h12345678));

    // Contention from reset: strict alternation starting with instr.
    rst = 1; tick(); rst = 0;
    obs_order.delete(); obs_ack_q.delete();
    pend[0] = 1; r_addr[0] = $urandom; pend[1] = 1; r_addr[1] = $urandom; r_we = 0;
    for (int k = 0; k < 40 && obs_order.size() < 4; k++) step_req(100, 100);
    wait_idle();
    check_eq("t3_count", 64'(obs_order.size() >= 4), 64'(1));
    if (obs_order.size() >= 4) begin
      for (int k = 0; k < 4; k++) check_eq("t3_order", 64'(obs_order[k]), 64'(k % 2));
      for (int k = 0; k < 3; k++)
        check_eq("t3_spacing", 64'(obs_ack_q[k+1] - obs_ack_q[k]), 64'(LAT + 2));
    end

    // Reset during the second ACCESS cycle of a data read.
    nd = n_ack[1];
    pend[1] = 1; r_addr[1] = 32'h8; r_we = 0;
    step_req(0, 0);
    step_req(0, 0);
    rst = 1;
    step_req(0, 0);
    rst = 0; pend[1] = 0;
    repeat (5) step_req(0, 0);
    check_eq("t4_no_ack", 64'(n_ack[1]), 64'(nd));
    t0 = cyc; pend[1] = 1; r_addr[1] = 32'h8; r_we = 0;
    wait_idle();
    check_eq("t4_served", 64'(n_ack[1]), 64'(nd + 1));
    check_eq("t4_ack_lat", 64'(obs_ack_cyc[1] - t0), 64'(LAT + 1));

    // Data request dropped one cycle after grant.
    nd = n_ack[1]; n_en_cyc = 0;
    t0 = cyc; pend[1] = 1; r_addr[1] = 32'h2C; r_we = 0;
    step_req(0, 0);
    pend[1] = 0;
    repeat (8) step_req(0, 0);
    check_eq("t5_one_ack", 64'(n_ack[1]), 64'(nd + 1));
    check_eq("t5_ack_lat", 64'(obs_ack_cyc[1] - t0), 64'(LAT + 1));
    check_eq("t5_en_cycles", 64'(n_en_cyc), 64'(LAT));

    // Random mixed traffic.
    for (int k = 0; k < 600; k++) step_req(35, 35);
    wait_idle();

    // LATENCY=1 instance: single read of 0x4.
    l1_i_req = 1; l1_i_addr = 32'h4;
    ack_at = -1; en_cnt = 0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (l1_mem_en) en_cnt++;
      if (k == 1) check_eq("l1_addr", 64'(l1_mem_addr), 64'(32'h4));
      if (l1_i_ack && ack_at < 0) begin ack_at = k; rd = l1_i_rdata; end
      @(posedge clk);
      #1;
      if (ack_at >= 0) l1_i_req = 0;
    end
    check_eq("l1_ack_at", 64'(ack_at), 64'(2));
    check_eq("l1_en_cycles", 64'(en_cnt), 64'(1));
    check_eq("l1_rdata", 64'(rd), 64'(32'hCAFEF00D));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
